csa_accumulator: RTL
====================

# csa_accumulator

Sequential carry-save accumulator that produces the redundant operands consumed by the 16-bit carry-save-to-binary final adder stage. It sums a stream of 16-bit words, modulo 2^16, using one 3:2 compressor row per beat, so no carry propagates within a clock cycle. On the last beat it hands over three vectors A, B and C, where the binary result is Z = A + B + (C << 1) mod 2^16. Bit C[i] carries weight 2^(i+1) and C[15] is discarded, exactly as the final adder expects.

## Interface
Parameters: none. Width is fixed at 16.
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept a beat
- in_data  input  16  word to accumulate
- in_last  input  1  marks the final beat of a group; valid only with in_valid
- out_valid  output  1  out_a, out_b, out_c and out_count hold a completed group
- out_ready  input  1  downstream takes the result
- out_a  output  16  accumulated sum vector
- out_b  output  16  final-beat word, not yet compressed
- out_c  output  16  carry vector; C[i] has weight 2^(i+1)
- out_count  output  8  beats in the group, saturating at 255

## Operation
- Internal registers: S[15:0], K[15:0] (carry vector, same weighting as out_c) and cnt[7:0].
- Two states:
  - ACCUM: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- A beat is accepted when in_valid && in_ready.
- Accepted beat with in_last = 0 (stay in ACCUM):
  - Let Ks = {K[14:0], 1'b0}.
  - S ← S ^ Ks ^ in_data.
  - K ← (S & Ks) | (S & in_data) | (Ks & in_data). The old K[15] is dropped (mod 2^16).
  - cnt ← cnt + 1, saturating at 255.
- Accepted beat with in_last = 1 (go to HOLD):
  - out_a ← S, out_b ← in_data, out_c ← K.
  - out_count ← cnt + 1, saturating at 255.
  - S, K and cnt are cleared to 0.
- HOLD: when out_ready = 1, go to ACCUM and drop out_valid in the next cycle.
- While out_valid = 1, out_a, out_b, out_c and out_count stay stable.
- Invariant: at the end of a group, out_a + out_b + (out_c << 1) mod 2^16 equals the modular sum of all beats in the group.
- A single-beat group gives out_a = 0, out_c = 0, out_b = in_data and out_count = 1.
- in_data and in_last are ignored when in_valid = 0 or in_ready = 0.
- Reset, at any time including mid-group or during HOLD:
  - state goes to ACCUM.
  - S, K, cnt, out_a, out_b, out_c and out_count go to 0.
  - out_valid = 0 and in_ready = 1 immediately.
  - A partially accumulated group is lost.

## Timing
- All outputs are registered, except in_ready, which decodes the state register directly (no combinational path from any input).
- Latency: out_valid rises in the cycle after the last beat is accepted.
- Throughput: one beat per cycle inside a group.
- A handoff costs one dead cycle: the HOLD cycle in which out_ready is sampled high accepts no input. in_ready returns to 1 in the next cycle.
- There is no input/output overlap, because in_ready = 0 whenever out_valid = 1.
- Critical path is one full-adder cell plus the register, independent of width.

## Configuration
- Macro CSA_ACC_COUNT_EN.
- Defined: cnt and out_count behave as described above.
- Undefined:
  - The cnt register is not built.
  - out_count is tied to 8'd0.
  - All other behaviour is identical.

## Test plan
- Single beat 0x1234 with in_last = 1 → in the next cycle out_valid = 1, out_a = 0x0000, out_b = 0x1234, out_c = 0x0000, out_count = 1.
- Beats 0xFFFF, 0x0001, then 0x0001 with in_last = 1 → out_a = 0xFFFE, out_b = 0x0001, out_c = 0x0001, out_count = 3. The final adder yields Z = 0x0001.
- Hold out_ready = 0 for 5 cycles after a group completes → outputs constant, in_ready = 0 throughout. Raise out_ready → out_valid = 0 and in_ready = 1 in the next cycle.
- Assert reset for 1 cycle after 2 beats of a group, then send 0x0005 with in_last = 1 → out_a = 0, out_b = 0x0005, out_c = 0, out_count = 1.
- 300-beat group of 0x0001 with back-to-back in_valid → out_count = 255 and A + B + (C << 1) mod 2^16 = 0x012C. With CSA_ACC_COUNT_EN undefined, out_count = 0.
- Random groups of 1–40 beats with random valid/ready gaps → a scoreboard checks A + B + (C << 1) mod 2^16 against the reference sum for every group.

Source files
------------

// File: rtl/csa_accumulator.sv
// Sequential carry-save accumulator feeding a 16-bit carry-save-to-binary final adder.
// Optional beat counter enabled by defining CSA_ACC_COUNT_EN; otherwise out_count reads 0.
module csa_accumulator (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_a,
  output logic [15:0] out_b,
  output logic [15:0] out_c,
  output logic [7:0]  out_count
);

  localparam int W = 16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0] s_q, s_d;
  logic [W-1:0] k_q, k_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] c_q, c_d;

  logic         beat_acc;
  logic         mid_acc;
  logic         last_acc;
  logic [W-1:0] ks;
  logic [W-1:0] sum_next;
  logic [W-1:0] carry_next;

  assign beat_acc = in_valid & in_ready;
  assign mid_acc  = beat_acc & ~in_last;
  assign last_acc = beat_acc & in_last;

  // One 3:2 compressor row: carry out of bit i lands at weight 2^(i+1), K[15] falls off.
  assign ks         = {k_q[W-2:0], 1'b0};
  assign sum_next   = s_q ^ ks ^ in_data;
  assign carry_next = (s_q & ks) | (s_q & in_data) | (ks & in_data);

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with <= so every flop samples pre-edge values; a
  // blocking assignment here would create simulation-order races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_ACCUM;
    else       state_q <= state_d;
  end

  // NOTE: the default assignment at the top keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCUM: if (last_acc)  state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = ST_ACCUM;
      default:                 state_d = ST_ACCUM;
    endcase
  end

  // Both handshake flags decode the state flop only, so no input reaches an output combinationally.
  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_HOLD);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    s_d = s_q;
    k_d = k_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    if (mid_acc) begin
      s_d = sum_next;
      k_d = carry_next;
    end else if (last_acc) begin
      a_d = s_q;
      b_d = in_data;
      c_d = k_q;
      s_d = '0;
      k_d = '0;
    end
  end

  // NOTE: data registers take the async reset too, because a reset mid-group
  // must discard the partial sum and clear the presented result immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= '0;
      k_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      s_q <= s_d;
      k_q <= k_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end

  assign out_a = a_q;
  assign out_b = b_q;
  assign out_c = c_q;

`ifdef CSA_ACC_COUNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] count_q, count_d;
  logic [7:0] cnt_inc;

  assign cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

  always_comb begin
    cnt_d   = cnt_q;
    count_d = count_q;
    if (mid_acc) begin
      cnt_d = cnt_inc;
    end else if (last_acc) begin
      count_d = cnt_inc;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`else
  assign out_count = 8'd0;
`endif

endmodule
